// File: rtl/gpu_clutloader.sv
// gpu_clutloader
//   Palette (CLUT) fetch engine. Driven by gpu_clutManager: when a palette load is
//   requested it reads each 16-entry packet (8 x 32-bit beats) from VRAM and writes
//   it into the CLUT cache RAM, pulsing o_incClutCount per packet and
//   o_endClutLoading once the manager reports no packets left.
//
// Ports
//   i_clk, i_nrst                 clock, synchronous active-low reset
//   i_isLoadingPalette            manager: load requested / in progress
//   i_adrClutCacheUpdate[14:0]    manager: VRAM packet address (32-byte units)
//   i_currentClutBlock[3:0]       manager: packet index
//   i_stillRemainingClutPacket    manager: more packets to fetch
//   o_incClutCount                pulse: packet fully written
//   o_endClutLoading              pulse: load finished
//   o_memReq / o_memAdr           VRAM read request and address
//   i_memAck                      arbiter accepted request
//   i_memDataValid / i_memData    read beat
//   o_clutWrEn/Adr/Data           CLUT cache write port, address {block, beat}
//   o_busy                        engine not idle
module gpu_clutloader #(
    parameter int BEAT_LOG2 = 3,
    parameter int DATA_W    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_isLoadingPalette,
    input  logic [14:0]            i_adrClutCacheUpdate,
    input  logic [3:0]             i_currentClutBlock,
    input  logic                   i_stillRemainingClutPacket,
    output logic                   o_incClutCount,
    output logic                   o_endClutLoading,
    output logic                   o_memReq,
    output logic [14:0]            o_memAdr,
    input  logic                   i_memAck,
    input  logic                   i_memDataValid,
    input  logic [DATA_W-1:0]      i_memData,
    output logic                   o_clutWrEn,
    output logic [3+BEAT_LOG2:0]   o_clutWrAdr,
    output logic [DATA_W-1:0]      o_clutWrData,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_INC,
        S_CHECK,
        S_END,
        S_GUARD
    } state_t;

    localparam logic [BEAT_LOG2-1:0] LAST_BEAT = '1;

    state_t                 r_state;
    state_t                 w_next;
    logic [14:0]            r_adr;
    logic [3:0]             r_blk;
    logic [BEAT_LOG2-1:0]   r_beat;
    logic                   w_wr;

    // Beats are only accepted while in DATA; stray beats elsewhere never write.
    assign w_wr = (r_state == S_DATA) && i_memDataValid;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Packet address, block index and beat counter
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_adr  <= '0;
            r_blk  <= '0;
            r_beat <= '0;
        end else begin
            if ((r_state == S_IDLE && i_isLoadingPalette) ||
                (r_state == S_CHECK && i_stillRemainingClutPacket)) begin
                r_adr <= i_adrClutCacheUpdate;
                r_blk <= i_currentClutBlock;
            end
            if (r_state == S_REQ && i_memAck) begin
                r_beat <= '0;
            end else if (w_wr) begin
                r_beat <= r_beat + BEAT_LOG2'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_isLoadingPalette) w_next = S_REQ;
            S_REQ:   if (i_memAck) w_next = S_DATA;
            S_DATA:  if (w_wr && r_beat == LAST_BEAT) w_next = S_INC;
            S_INC:   w_next = S_CHECK;
            S_CHECK: w_next = i_stillRemainingClutPacket ? S_REQ : S_END;
            S_END:   w_next = S_GUARD;
            S_GUARD: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs; address/data buses are zeroed when not qualified
    always_comb begin
        o_memReq         = 1'b0;
        o_memAdr         = '0;
        o_clutWrEn       = 1'b0;
        o_clutWrAdr      = '0;
        o_clutWrData     = '0;
        o_incClutCount   = 1'b0;
        o_endClutLoading = 1'b0;
        o_busy           = (r_state != S_IDLE);
        case (r_state)
            S_REQ: begin
                o_memReq = 1'b1;
                o_memAdr = r_adr;
            end
            S_DATA: begin
                if (w_wr) begin
                    o_clutWrEn   = 1'b1;
                    o_clutWrAdr  = {r_blk, r_beat};
                    o_clutWrData = i_memData;
                end
            end
            S_INC:   o_incClutCount   = 1'b1;
            S_END:   o_endClutLoading = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpu_clutloader.sv
// Testbench for gpu_clutloader: directed loads with a scoreboard of expected
// CLUT writes; a negedge monitor pops and compares every write it sees.
module tb_gpu_clutloader;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_isLoadingPalette;
    logic [14:0] i_adrClutCacheUpdate;
    logic [3:0]  i_currentClutBlock;
    logic        i_stillRemainingClutPacket;
    logic        o_incClutCount;
    logic        o_endClutLoading;
    logic        o_memReq;
    logic [14:0] o_memAdr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_clutWrEn;
    logic [6:0]  o_clutWrAdr;
    logic [31:0] o_clutWrData;
    logic        o_busy;

    always #5 clk = ~clk;

    gpu_clutloader #(.BEAT_LOG2(3), .DATA_W(32)) dut (
        .i_clk                      (clk),
        .i_nrst                     (i_nrst),
        .i_isLoadingPalette         (i_isLoadingPalette),
        .i_adrClutCacheUpdate       (i_adrClutCacheUpdate),
        .i_currentClutBlock         (i_currentClutBlock),
        .i_stillRemainingClutPacket (i_stillRemainingClutPacket),
        .o_incClutCount             (o_incClutCount),
        .o_endClutLoading           (o_endClutLoading),
        .o_memReq                   (o_memReq),
        .o_memAdr                   (o_memAdr),
        .i_memAck                   (i_memAck),
        .i_memDataValid             (i_memDataValid),
        .i_memData                  (i_memData),
        .o_clutWrEn                 (o_clutWrEn),
        .o_clutWrAdr                (o_clutWrAdr),
        .o_clutWrData               (o_clutWrData),
        .o_busy                     (o_busy)
    );

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  inc_seen = 0;
    int  end_seen = 0;
    int  writes_seen = 0;
    int  exp_inc = 0;
    int  exp_end = 0;
    int  exp_writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every CLUT write must match the oldest expected entry
    always @(negedge clk) begin
        if (o_clutWrEn) begin
            wr_t e;
            writes_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write adr=%0h data=%0h required=no write", o_clutWrAdr, o_clutWrData);
            end else begin
                e = sb.pop_front();
                if (o_clutWrAdr !== e.adr || o_clutWrData !== e.data) begin
                    errors++;
                    $display("FAIL clut_write adr actual=%0h required=%0h data actual=%0h required=%0h",
                             o_clutWrAdr, e.adr, o_clutWrData, e.data);
                end
            end
        end
        if (o_incClutCount)   inc_seen++;
        if (o_endClutLoading) end_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_data(input logic [14:0] adr, input logic [3:0] blk, input int b);
        return {blk, 4'(b), 8'h5A, 1'b0, adr};
    endfunction

    // Serve one packet: wait for the request, optionally delay the ack (with
    // stray beats in REQ), then deliver nbeats beats with random gaps.
    task automatic do_packet(input logic [14:0] adr, input logic [3:0] blk, input int ack_dly,
                             input int gap_max, input int nbeats, output int last_cyc);
        int  n;
        int  g;
        wr_t e;
        n = 0;
        last_cyc = cyc;
        while (!o_memReq && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", o_memReq, 1);
        chk("req_adr", o_memAdr, adr);
        for (int d = 0; d < ack_dly; d++) begin
            i_memDataValid = 1'b1;
            i_memData      = 32'hDEAD_0000 | 32'(d);
            tick();
            chk("req_stable", {o_memReq, o_memAdr}, {1'b1, adr});
        end
        i_memDataValid = 1'b0;
        i_memAck       = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) tick();
            i_memDataValid = 1'b1;
            i_memData      = beat_data(adr, blk, b);
            e.adr  = {blk, 3'(b)};
            e.data = beat_data(adr, blk, b);
            sb.push_back(e);
            exp_writes++;
            last_cyc = cyc;
            tick();
            i_memDataValid = 1'b0;
        end
    endtask

    task automatic wait_inc();
        int n;
        n = 0;
        while (!o_incClutCount && n < 40) begin
            tick();
            n++;
        end
        chk("inc_pulse", o_incClutCount, 1);
        exp_inc++;
    endtask

    // Full load with a manager model stepping blk/adr per packet; the loading
    // flag stays high through END and GUARD and drops in the first IDLE cycle.
    task automatic run_load(input logic [14:0] adr0, input logic [3:0] blk0, input int npk,
                            input int ack_dly, input int gap_max);
        int last;
        last = 0;
        i_adrClutCacheUpdate       = adr0;
        i_currentClutBlock         = blk0;
        i_stillRemainingClutPacket = 1'b0;
        i_isLoadingPalette         = 1'b1;
        for (int p = 0; p < npk; p++) begin
            do_packet(adr0 + 15'(p), blk0 + 4'(p), ack_dly, gap_max, 8, last);
            wait_inc();
            tick();
            if (p + 1 < npk) begin
                i_adrClutCacheUpdate       = adr0 + 15'(p + 1);
                i_currentClutBlock         = blk0 + 4'(p + 1);
                i_stillRemainingClutPacket = 1'b1;
            end else begin
                i_stillRemainingClutPacket = 1'b0;
            end
            tick();
        end
        chk("end_pulse", o_endClutLoading, 1);
        chk("end_latency", 64'(cyc - last), 3);
        exp_end++;
        tick();
        chk("guard_busy", o_busy, 1);
        chk("guard_end_low", o_endClutLoading, 0);
        tick();
        chk("idle_busy", o_busy, 0);
        chk("no_retrigger", o_memReq, 0);
        i_isLoadingPalette = 1'b0;
        tick();
        chk("idle_stays", o_busy, 0);
    endtask

    initial begin
        int last;
        i_nrst                     = 1'b0;
        i_isLoadingPalette         = 1'b0;
        i_adrClutCacheUpdate       = '0;
        i_currentClutBlock         = '0;
        i_stillRemainingClutPacket = 1'b0;
        i_memAck                   = 1'b0;
        i_memDataValid             = 1'b0;
        i_memData                  = '0;
        repeat (2) tick();
        chk("rst_outputs", {o_busy, o_memReq, o_memAdr, o_clutWrEn, o_clutWrAdr, o_clutWrData,
                            o_incClutCount, o_endClutLoading}, 0);
        i_nrst = 1'b1;
        tick();

        // Stray beats while idle
        for (int i = 0; i < 3; i++) begin
            i_memDataValid = 1'b1;
            i_memData      = 32'hBAD0_0000 | 32'(i);
            #1;
            chk("idle_stray_wr", o_clutWrEn, 0);
            tick();
        end
        i_memDataValid = 1'b0;
        chk("idle_stray_busy", o_busy, 0);

        // 4bpp, 8bpp, delayed ack with gaps
        run_load(15'h1234, 4'd0, 1, 0, 0);
        run_load(15'h0400, 4'd0, 16, 0, 0);
        run_load(15'h2000, 4'd3, 2, 5, 3);

        // Reset after beat 3 of the third packet
        i_adrClutCacheUpdate       = 15'h3000;
        i_currentClutBlock         = 4'd0;
        i_stillRemainingClutPacket = 1'b0;
        i_isLoadingPalette         = 1'b1;
        for (int p = 0; p < 2; p++) begin
            do_packet(15'h3000 + 15'(p), 4'(p), 0, 0, 8, last);
            wait_inc();
            tick();
            i_adrClutCacheUpdate       = 15'h3000 + 15'(p + 1);
            i_currentClutBlock         = 4'(p + 1);
            i_stillRemainingClutPacket = 1'b1;
            tick();
        end
        do_packet(15'h3002, 4'd2, 0, 0, 4, last);
        i_nrst                     = 1'b0;
        i_isLoadingPalette         = 1'b0;
        i_stillRemainingClutPacket = 1'b0;
        tick();
        i_nrst = 1'b1;
        chk("midrst_outputs", {o_busy, o_memReq, o_memAdr, o_clutWrEn, o_clutWrAdr, o_clutWrData,
                               o_incClutCount, o_endClutLoading}, 0);
        for (int i = 0; i < 4; i++) begin
            i_memDataValid = 1'b1;
            i_memData      = 32'h1A7E_0000 | 32'(i);
            #1;
            chk("late_beat_wr", o_clutWrEn, 0);
            tick();
        end
        i_memDataValid = 1'b0;
        chk("sb_drained_rst", 64'(sb.size()), 0);

        // Clean restart
        run_load(15'h0100, 4'd5, 1, 0, 0);

        repeat (3) tick();
        chk("inc_count", 64'(inc_seen), 64'(exp_inc));
        chk("end_count", 64'(end_seen), 64'(exp_end));
        chk("write_count", 64'(writes_seen), 64'(exp_writes));
        chk("sb_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
